// File: rtl/b_uart_if.sv
// rtl/b_uart_if.sv - parallel-side handshake bundle of the b_uart console UART
// The host drives wr/tx_data/rd; the UART returns busy/rx_data/valid.
interface b_uart_if;
   logic       wr;
   logic [7:0] tx_data;
   logic       busy;
   logic       rd;
   logic [7:0] rx_data;
   logic       valid;

   modport master (
      output wr, tx_data, rd,
      input  busy, rx_data, valid
   );

   modport slave (
      input  wr, tx_data, rd,
      output busy, rx_data, valid
   );
endinterface

// File: rtl/b_uart.sv
// rtl/b_uart.sv - byte-wide 8N1 UART, independent TX and mid-bit sampling RX
// Optional BUART_LOOPBACK_EN feeds the registered tx back into the receiver.
module b_uart #(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic     clk,
   input  logic     resetq,
   input  logic     rx,
   output logic     tx,
   b_uart_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

   // ---------------- transmitter ----------------
   state_t      tx_state_q, tx_state_d;
   logic [15:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]  tx_idx_q, tx_idx_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic        tx_q, tx_d;

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         tx_state_q <= S_IDLE;
         tx_cnt_q   <= '0;
         tx_idx_q   <= '0;
         tx_shift_q <= '0;
         tx_q       <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_idx_q   <= tx_idx_d;
         tx_shift_q <= tx_shift_d;
         tx_q       <= tx_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_idx_d   = tx_idx_q;
      tx_shift_d = tx_shift_q;
      tx_d       = tx_q;
      case (tx_state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (bus.wr) begin
               tx_state_d = S_START;
               tx_shift_d = bus.tx_data;
               tx_cnt_d   = '0;
               tx_d       = 1'b0;
            end
         end
         S_START: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_state_d = S_DATA;
               tx_cnt_d   = '0;
               tx_idx_d   = '0;
               tx_d       = tx_shift_q[0];
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
            end else begin
               tx_cnt_d = tx_cnt_q + 16'd1;
            end
         end
         S_DATA: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d = '0;
               if (tx_idx_q == 3'd7) begin
                  tx_state_d = S_STOP;
                  tx_d       = 1'b1;
               end else begin
                  tx_idx_d   = tx_idx_q + 3'd1;
                  tx_d       = tx_shift_q[0];
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
               end
            end else begin
               tx_cnt_d = tx_cnt_q + 16'd1;
            end
         end
         S_STOP: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_state_d = S_IDLE;
               tx_cnt_d   = '0;
            end else begin
               tx_cnt_d = tx_cnt_q + 16'd1;
            end
         end
         default: tx_state_d = S_IDLE;
      endcase
   end

   assign tx       = tx_q;
   assign bus.busy = (tx_state_q != S_IDLE);

   // ---------------- receiver ----------------
   logic rx_in;
`ifdef BUART_LOOPBACK_EN
   assign rx_in = tx_q;
`else
   assign rx_in = rx;
`endif

   // rx_prev_q holds the previous synchronized level for start-edge detection
   logic rx_s1_q, rx_s2_q, rx_prev_q;

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_s1_q   <= rx_in;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
      end
   end

   state_t      rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]  rx_idx_q, rx_idx_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic [7:0]  rx_data_q, rx_data_d;
   logic        valid_q, valid_d;
   logic        rx_set;

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         rx_state_q <= S_IDLE;
         rx_cnt_q   <= '0;
         rx_idx_q   <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         valid_q    <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_idx_q   <= rx_idx_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         valid_q    <= valid_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_idx_d   = rx_idx_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      rx_set     = 1'b0;
      case (rx_state_q)
         S_IDLE: begin
            if (rx_prev_q && !rx_s2_q) begin
               rx_state_d = S_START;
               rx_cnt_d   = '0;
            end
         end
         S_START: begin
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d   = '0;
               rx_idx_d   = '0;
               rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + 16'd1;
            end
         end
         S_DATA: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
               if (rx_idx_q == 3'd7) begin
                  rx_state_d = S_STOP;
               end else begin
                  rx_idx_d = rx_idx_q + 3'd1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 16'd1;
            end
         end
         S_STOP: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_state_d = S_IDLE;
               rx_cnt_d   = '0;
               if (rx_s2_q) begin
                  rx_data_d = rx_shift_q;
                  rx_set    = 1'b1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 16'd1;
            end
         end
         default: rx_state_d = S_IDLE;
      endcase
      // a new byte wins over a simultaneous acknowledge
      valid_d = rx_set | (valid_q & ~bus.rd);
   end

   assign bus.rx_data = rx_data_q;
   assign bus.valid   = valid_q;

endmodule

// File: tb/tb_b_uart.sv
// tb/tb_b_uart.sv - self-checking bench for b_uart with a frame-level reference model
module tb_b_uart;
   localparam int CPB = 16;
   localparam int H   = CPB / 2;

   logic clk = 1'b0;
   logic resetq;
   logic rx;
   logic tx;

   b_uart_if bus ();

   b_uart #(.CLKS_PER_BIT(CPB)) dut (
      .clk    (clk),
      .resetq (resetq),
      .rx     (rx),
      .tx     (tx),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;
   int rises   = 0;
   int rise_cyc = 0;
   int width   = 0;
   int max_w   = 0;
   int fall_cyc = 0;
   logic v_prev = 1'b0;
   logic [7:0] rise_q[$];

   always @(posedge clk) cyc = cyc + 1;

   always @(negedge clk) begin
      if (!resetq) begin
         v_prev = 1'b0;
      end else begin
         if (bus.valid && !v_prev) begin
            rises    = rises + 1;
            rise_cyc = cyc;
            width    = 0;
            rise_q.push_back(bus.rx_data);
         end
         if (bus.valid) begin
            width = width + 1;
            if (width > max_w) max_w = width;
         end
         v_prev = bus.valid;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic frame_bit(input logic [7:0] d, input int b);
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return d[b-1];
   endfunction

   task automatic tx_frame(input logic [7:0] d, input string tag);
      logic txs [200];
      logic bz  [200];
      int   first_idle;
      logic ok;
      @(negedge clk);
      bus.wr      = 1'b1;
      bus.tx_data = d;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         txs[k] = tx;
         bz[k]  = bus.busy;
         if (k == 0) bus.wr = 1'b0;
         if (k == 40) begin
            bus.wr      = 1'b1;
            bus.tx_data = ~d;
         end
         if (k == 41) bus.wr = 1'b0;
      end
      for (int b = 0; b < 10; b++) begin
         ok = 1'b1;
         for (int j = 0; j < CPB; j++)
            if (txs[b*CPB+j] !== frame_bit(d, b)) ok = 1'b0;
         chk($sformatf("%s_bit%0d", tag, b), {31'd0, ok}, 32'd1);
      end
      first_idle = 200;
      for (int k = 199; k >= 0; k--)
         if (!bz[k]) first_idle = k;
      chk({tag, "_busy_len"}, first_idle, 10 * CPB);
      chk({tag, "_wr_ignored"}, {30'd0, bz[199], txs[199]}, 32'd1);
   endtask

   task automatic send_rx(input logic [7:0] d, input logic stop_ok);
      for (int b = 0; b < 10; b++) begin
         if (b == 0) fall_cyc = cyc;
         rx = (b == 9) ? stop_ok : frame_bit(d, b);
         repeat (CPB) @(negedge clk);
      end
      rx = 1'b1;
   endtask

   int         r0;
   int         qb;
   int         lat;
   logic [7:0] exp_rx;
   logic [7:0] rd_byte;
   logic       sok;
   logic [7:0] exp_q[$];

   initial begin
      resetq      = 1'b0;
      rx          = 1'b1;
      bus.wr      = 1'b0;
      bus.tx_data = 8'h00;
      bus.rd      = 1'b0;
      exp_rx      = 8'h00;
      repeat (3) @(negedge clk);
      resetq = 1'b1;
      @(negedge clk);
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_valid", {31'd0, bus.valid}, 32'd0);
      chk("rst_rx_data", {24'd0, bus.rx_data}, 32'h00);

      tx_frame(8'hA5, "tx_a5");
      for (int i = 0; i < 2; i++)
         tx_frame(8'($urandom), $sformatf("tx_rnd%0d", i));

`ifndef BUART_LOOPBACK_EN
      // single frame, held until acknowledged
      bus.rd = 1'b1;
      @(negedge clk);
      bus.rd = 1'b0;
      r0 = rises;
      send_rx(8'h3C, 1'b1);
      exp_rx = 8'h3C;
      repeat (5) @(negedge clk);
      chk("rx3c_rises", rises - r0, 1);
      chk("rx3c_data", {24'd0, bus.rx_data}, {24'd0, exp_rx});
      lat = rise_cyc - fall_cyc;
      chk("rx3c_latency", {31'd0, (lat >= 1 + H + 9*CPB) && (lat <= 3 + H + 9*CPB)}, 32'd1);
      repeat (20) @(negedge clk);
      chk("rx3c_valid_held", {31'd0, bus.valid}, 32'd1);
      bus.rd = 1'b1;
      @(negedge clk);
      bus.rd = 1'b0;
      chk("rx3c_rd_clear", {31'd0, bus.valid}, 32'd0);

      // rd tied high: back-to-back frames give one-cycle pulses
      bus.rd = 1'b1;
      r0 = rises;
      qb = rise_q.size();
      max_w = 0;
      send_rx(8'h48, 1'b1);
      send_rx(8'h69, 1'b1);
      exp_rx = 8'h69;
      repeat (5) @(negedge clk);
      chk("b2b_rises", rises - r0, 2);
      rd_byte = (rise_q.size() > qb) ? rise_q[qb] : 8'hxx;
      chk("b2b_first", {24'd0, rd_byte}, 32'h48);
      rd_byte = (rise_q.size() > qb + 1) ? rise_q[qb+1] : 8'hxx;
      chk("b2b_second", {24'd0, rd_byte}, 32'h69);
      chk("b2b_pulse_width", max_w, 1);

      // random frames, some with framing errors
      r0 = rises;
      qb = rise_q.size();
      exp_q.delete();
      for (int i = 0; i < 8; i++) begin
         rd_byte = 8'($urandom);
         sok = ($urandom_range(0, 3) != 0);
         send_rx(rd_byte, sok);
         if (sok) begin
            exp_q.push_back(rd_byte);
            exp_rx = rd_byte;
         end
         repeat (2 * CPB) @(negedge clk);
      end
      chk("rnd_rises", rises - r0, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         rd_byte = (rise_q.size() > qb + i) ? rise_q[qb+i] : 8'hxx;
         chk($sformatf("rnd_byte%0d", i), {24'd0, rd_byte}, {24'd0, exp_q[i]});
      end
      chk("rnd_last_data", {24'd0, bus.rx_data}, {24'd0, exp_rx});

      // glitch and framing error are both rejected
      bus.rd = 1'b0;
      r0 = rises;
      rx = 1'b0;
      repeat (CPB / 4) @(negedge clk);
      rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      chk("glitch_rises", rises - r0, 0);
      send_rx(8'h55, 1'b0);
      repeat (2 * CPB) @(negedge clk);
      chk("ferr_rises", rises - r0, 0);
      chk("ferr_valid", {31'd0, bus.valid}, 32'd0);
      chk("ferr_data", {24'd0, bus.rx_data}, {24'd0, exp_rx});
`else
      bus.rd = 1'b1;
      @(negedge clk);
      bus.rd = 1'b0;
      r0 = rises;
      @(negedge clk);
      bus.wr      = 1'b1;
      bus.tx_data = 8'hC3;
      fall_cyc    = cyc;
      @(negedge clk);
      bus.wr = 1'b0;
      for (int k = 0; k < 12 * CPB; k++) begin
         @(negedge clk);
         if (k == 40) begin
            bus.wr      = 1'b1;
            bus.tx_data = 8'h11;
         end
         if (k == 41) bus.wr = 1'b0;
      end
      chk("lb_rises", rises - r0, 1);
      chk("lb_data", {24'd0, bus.rx_data}, 32'hC3);
      chk("lb_valid", {31'd0, bus.valid}, 32'd1);
      lat = rise_cyc - fall_cyc;
      chk("lb_latency", {31'd0, (lat >= 9*CPB) && (lat <= 11*CPB)}, 32'd1);
      repeat (12 * CPB) @(negedge clk);
      chk("lb_wr_ignored", rises - r0, 1);
`endif

      // reset in mid-frame forces tx high at once
      @(negedge clk);
      bus.wr      = 1'b1;
      bus.tx_data = 8'h00;
      @(negedge clk);
      bus.wr = 1'b0;
      repeat (30) @(negedge clk);
      chk("midrst_tx_low", {31'd0, tx}, 32'd0);
      resetq = 1'b0;
      #1;
      chk("midrst_tx", {31'd0, tx}, 32'd1);
      chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
      chk("midrst_valid", {31'd0, bus.valid}, 32'd0);
      repeat (2) @(negedge clk);
      resetq = 1'b1;
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/b_uart.md
# b_uart

Byte-wide 8N1 UART with an independent transmitter and receiver. It is the serial console of the SoC and is also used in simulation as a host-side receiver that decodes the SoC's `tx` line into bytes. The bit rate comes from a fixed integer clock divider. The receiver is a mid-bit sampling state machine with a sticky `valid` flag that `rd` acknowledges.

## Interface
- `CLKS_PER_BIT`, default 104: clock cycles per serial bit; legal range 4..65535.
- `clk`, in, 1: single system clock; all logic is on its rising edge.
- `resetq`, in, 1: asynchronous, active-low reset.
- `rx`, in, 1: serial input; asynchronous to `clk`; idles high.
- `tx`, out, 1: serial output; idles high.
- `wr`, in, 1: transmit request; `tx_data` is accepted when `wr`=1 and `busy`=0.
- `tx_data`, in, 8: byte to transmit.
- `rd`, in, 1: read acknowledge; clears `valid`.
- `rx_data`, out, 8: last correctly framed received byte.
- `busy`, out, 1: transmitter is sending a frame.
- `valid`, out, 1: `rx_data` holds a byte that has not been acknowledged.

## Operation
- Frame format: start bit (0), then data bits 0..7 (LSB first), then one stop bit (1). No parity.
- Transmitter states: IDLE, START, DATA, STOP.
  - In IDLE with `wr`=1: latch `tx_data` into a shift register and move to START.
  - Each state lasts `CLKS_PER_BIT` cycles. DATA lasts 8 bit periods, shifting right and driving the LSB onto `tx`.
  - STOP drives `tx`=1, then returns to IDLE.
  - `busy`=1 in every state except IDLE.
  - `wr` while `busy`=1 is ignored and the byte is not queued.
- Receiver front end: `rx` passes through a 2-flop synchronizer.
- Receiver states: IDLE, START, DATA, STOP.
  - IDLE: a synchronized 1→0 transition enters START.
  - START: after `CLKS_PER_BIT/2` cycles (integer divide), re-sample. If the line is 1, it was a false start; return to IDLE.
  - DATA: sample each data bit every `CLKS_PER_BIT` cycles from that mid-point and shift it in, LSB first.
  - STOP: sample the stop bit at its mid-point.
  - Stop bit = 1: load `rx_data` and set `valid`=1.
  - Stop bit = 0 (framing error): discard the byte; `rx_data` and `valid` are unchanged.
  - After the stop sample, always return to IDLE. A new start edge can therefore be detected in the second half of the stop bit.
- `valid` rules:
  - Cleared on the clock edge where `rd`=1.
  - If a set and a clear occur in the same cycle, the set wins.
  - With `rd` tied high, `valid` is a one-cycle pulse per received byte.
- Overrun: a new byte overwrites `rx_data` even if `valid`=1. No error flag.

## Timing
- Reset values: `tx`=1, `busy`=0, `valid`=0, `rx_data`=8'h00; both state machines in IDLE; synchronizer flops = 1.
- Reset asserted mid-frame aborts the frame immediately. `tx` goes high asynchronously.
- TX latency:
  - `wr` sampled at edge N → `busy`=1 and `tx`=0 from edge N.
  - `busy` falls exactly 10×`CLKS_PER_BIT` cycles after edge N.
  - A new `wr` is accepted in the first cycle `busy`=0, so back-to-back frames have no idle gap.
- RX latency: `valid` rises 2 + `CLKS_PER_BIT/2` + 9×`CLKS_PER_BIT` (±1) cycles after the falling start edge on the pin. The range accounts for synchronizer phase.
- Tolerated baud mismatch: ±3 %.

## Configuration
- `BUART_LOOPBACK_EN`:
  - Defined: the receiver input is internally connected to the transmitter output (registered `tx`); the `rx` pin is ignored. `tx` still drives the pin.
  - Undefined: the receiver uses the `rx` pin. This is the default build.

## Test plan
- Reset with `resetq`=0, then release → `tx`=1, `busy`=0, `valid`=0, `rx_data`=00.
- `CLKS_PER_BIT`=16; pulse `wr` with `tx_data`=8'hA5 → `tx` shows 0,1,0,1,0,0,1,0,1,1 with each bit 16 cycles wide; `busy` is high for exactly 160 cycles.
- Drive an `rx` frame for 8'h3C with `rd`=0 → `valid` rises once, `rx_data`=3C, and `valid` stays high until a one-cycle `rd` pulse clears it on the next edge.
- `rd` tied 1; send 8'h48 then 8'h69 back-to-back → two one-cycle `valid` pulses with `rx_data`=48 then 69.
- `rx` low glitch of `CLKS_PER_BIT/4` cycles; a separate frame for 8'h55 with stop bit 0 → no `valid` for either; `rx_data` unchanged.
- `BUART_LOOPBACK_EN` defined; `wr` 8'hC3 with `rd`=0 → `valid`=1 and `rx_data`=C3 about 10×`CLKS_PER_BIT` cycles after `wr`; `wr` during `busy` is ignored.
